// File: rtl/life_hud_ctrl.sv
// Life/HUD controller: life count, invulnerability/death FSM, per-mask break/fill
// animation and a registered per-pixel mask hit query. Optional macro: LIFE_HUD_FLASH_EN.
module life_hud_ctrl #(
  parameter int NUM_MASKS     = 5,
  parameter int LIFE_W        = 4,
  parameter int COORD_W       = 10,
  parameter int MASK_X0       = 20,
  parameter int MASK_Y0       = 20,
  parameter int MASK_PITCH    = 40,
  parameter int MASK_SX       = 30,
  parameter int MASK_SY       = 36,
  parameter int INVULN_FRAMES = 60,
  parameter int ANIM_FRAMES   = 8
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   frame_vs,
  input  logic                   dmg_req,
  input  logic                   heal_req,
  input  logic                   revive_req,
  input  logic [COORD_W-1:0]     DrawX,
  input  logic [COORD_W-1:0]     DrawY,
  output logic [LIFE_W-1:0]      life,
  output logic                   dead,
  output logic                   invuln,
  output logic [2*NUM_MASKS-1:0] mask_state,
  output logic                   mask_hit,
  output logic [3:0]             mask_hit_idx,
  output logic [1:0]             mask_hit_state
);

  localparam logic [1:0] M_EMPTY = 2'b00;
  localparam logic [1:0] M_FULL  = 2'b01;
  localparam logic [1:0] M_BREAK = 2'b10;
  localparam logic [1:0] M_FILL  = 2'b11;

  localparam int INV_W  = $clog2(INVULN_FRAMES + 1);
  localparam int ANIM_W = $clog2(ANIM_FRAMES + 1);

  localparam logic [LIFE_W-1:0] LIFE_MAX  = LIFE_W'(NUM_MASKS);
  localparam logic [INV_W-1:0]  INV_LOAD  = INV_W'(INVULN_FRAMES);
  localparam logic [ANIM_W-1:0] ANIM_LOAD = ANIM_W'(ANIM_FRAMES);

  typedef enum logic [1:0] {
    ST_ALIVE  = 2'd0,
    ST_INVULN = 2'd1,
    ST_DEAD   = 2'd2
  } state_t;

  state_t             state;
  logic               frame_q;
  logic               tick;
  logic [INV_W-1:0]   inv_cnt;
  logic [1:0]         mask_st  [NUM_MASKS];
  logic [ANIM_W-1:0]  anim_cnt [NUM_MASKS];

  logic dmg_ok;
  logic heal_ok;
  logic revive_ok;

  assign tick = ~frame_q & frame_vs;

  // A same-cycle damage request always drops the heal.
  assign dmg_ok    = dmg_req && (state == ST_ALIVE) && (life != '0);
  assign heal_ok   = heal_req && !dmg_req && (state != ST_DEAD) && (life != LIFE_MAX);
  assign revive_ok = revive_req && (state == ST_DEAD);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_q <= 1'b1;
      state   <= ST_ALIVE;
      life    <= LIFE_MAX;
      dead    <= 1'b0;
      invuln  <= 1'b0;
      inv_cnt <= '0;
    end else begin
      frame_q <= frame_vs;
      case (state)
        ST_ALIVE: begin
          if (dmg_ok) begin
            life <= life - LIFE_W'(1);
            if (life == LIFE_W'(1)) begin
              state <= ST_DEAD;
              dead  <= 1'b1;
            end else begin
              state   <= ST_INVULN;
              invuln  <= 1'b1;
              inv_cnt <= INV_LOAD;
            end
          end else if (heal_ok) begin
            life <= life + LIFE_W'(1);
          end
        end
        ST_INVULN: begin
          if (heal_ok) begin
            life <= life + LIFE_W'(1);
          end
          if (tick) begin
            if (inv_cnt <= INV_W'(1)) begin
              state   <= ST_ALIVE;
              invuln  <= 1'b0;
              inv_cnt <= '0;
            end else begin
              inv_cnt <= inv_cnt - INV_W'(1);
            end
          end
        end
        ST_DEAD: begin
          if (revive_ok) begin
            state <= ST_ALIVE;
            dead  <= 1'b0;
            life  <= LIFE_MAX;
          end
        end
        default: begin
          state   <= ST_ALIVE;
          dead    <= 1'b0;
          invuln  <= 1'b0;
          inv_cnt <= '0;
        end
      endcase
    end
  end

  // Requests retarget a mask and restart its animation; ticks only age running animations.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NUM_MASKS; i++) begin
        mask_st[i]  <= M_FULL;
        anim_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_MASKS; i++) begin
        if (revive_ok) begin
          mask_st[i]  <= M_FILL;
          anim_cnt[i] <= ANIM_LOAD;
        end else if (dmg_ok && (i == int'(life) - 1)) begin
          mask_st[i]  <= M_BREAK;
          anim_cnt[i] <= ANIM_LOAD;
        end else if (heal_ok && (i == int'(life))) begin
          mask_st[i]  <= M_FILL;
          anim_cnt[i] <= ANIM_LOAD;
        end else if (tick && (anim_cnt[i] != '0)) begin
          anim_cnt[i] <= anim_cnt[i] - ANIM_W'(1);
          if (anim_cnt[i] == ANIM_W'(1)) begin
            if (mask_st[i] == M_BREAK) mask_st[i] <= M_EMPTY;
            else if (mask_st[i] == M_FILL) mask_st[i] <= M_FULL;
          end
        end
      end
    end
  end

  always_comb begin
    mask_state = '0;
    for (int i = 0; i < NUM_MASKS; i++) begin
      mask_state[2*i +: 2] = mask_st[i];
    end
  end

  // Box compare in int so boxes beyond the coordinate range never alias back.
  int   hit_dx;
  int   hit_dy;
  logic hit_any;
  logic [3:0] hit_idx;
  logic [1:0] hit_st;

  assign hit_dx = int'(DrawX);
  assign hit_dy = int'(DrawY);

  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    hit_st  = M_EMPTY;
    for (int i = NUM_MASKS - 1; i >= 0; i--) begin
      if ((hit_dy >= MASK_Y0) && (hit_dy < MASK_Y0 + MASK_SY) &&
          (hit_dx >= MASK_X0 + i * MASK_PITCH) &&
          (hit_dx < MASK_X0 + i * MASK_PITCH + MASK_SX)) begin
        hit_any = 1'b1;
        hit_idx = 4'(i);
        hit_st  = mask_st[i];
      end
    end
  end

  logic show;

`ifdef LIFE_HUD_FLASH_EN
  logic       flash_on;
  logic [1:0] flash_cnt;

  // Phase is held ON outside INVULN, so each hit starts the blink from ON.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      flash_on  <= 1'b1;
      flash_cnt <= '0;
    end else if (state != ST_INVULN) begin
      flash_on  <= 1'b1;
      flash_cnt <= '0;
    end else if (tick) begin
      flash_cnt <= flash_cnt + 2'd1;
      if (flash_cnt == 2'd3) flash_on <= ~flash_on;
    end
  end

  assign show = flash_on;
`else
  assign show = 1'b1;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      mask_hit       <= 1'b0;
      mask_hit_idx   <= '0;
      mask_hit_state <= M_EMPTY;
    end else begin
      mask_hit       <= hit_any & show;
      mask_hit_idx   <= hit_idx;
      mask_hit_state <= hit_st;
    end
  end

endmodule
